// File: rtl/result_display.sv
// Captures a 5-bit adder/subtractor result, converts it to sign plus two decimal
// digits and scans it onto a 4-digit active-low seven-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank the tens digit when it is zero).
module result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] result,
  input  logic       mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  // Internal digit codes: 0..9 are numerals, the rest are symbols.
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  logic [4:0]    held_val_r;
  logic          held_mode_r;
  logic          neg_r;
  logic [1:0]    tens_r;
  logic [3:0]    ones_r;
  logic [PW-1:0] presc_r;
  logic [1:0]    idx_r;
  logic [6:0]    seg_r;
  logic [3:0]    an_r;

  logic          neg_s;
  logic [4:0]    mag_s;
  logic [4:0]    tens_sub_s;
  logic [1:0]    tens_s;
  logic [3:0]    ones_s;
  logic [PW-1:0] presc_next_s;
  logic [1:0]    idx_next_s;
  logic [3:0]    digit_s;

  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:       pattern = 7'b1000000;
      4'd1:       pattern = 7'b1111001;
      4'd2:       pattern = 7'b0100100;
      4'd3:       pattern = 7'b0110000;
      4'd4:       pattern = 7'b0011001;
      4'd5:       pattern = 7'b0010010;
      4'd6:       pattern = 7'b0000010;
      4'd7:       pattern = 7'b1111000;
      4'd8:       pattern = 7'b0000000;
      4'd9:       pattern = 7'b0010000;
      CODE_MINUS: pattern = 7'b0111111;
      default:    pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  // Capture register: reset takes priority over a coincident load.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_val_r  <= 5'd0;
      held_mode_r <= 1'b0;
    end else if (load) begin
      held_val_r  <= result;
      held_mode_r <= mode;
    end else begin
      held_val_r  <= held_val_r;
      held_mode_r <= held_mode_r;
    end
  end

  // Sign/magnitude and decimal split; magnitude never exceeds 31.
  always_comb begin
    neg_s = held_mode_r & held_val_r[4];
    if (neg_s) begin
      mag_s = 5'd0 - held_val_r;
    end else begin
      mag_s = held_val_r;
    end
    if (mag_s >= 5'd30) begin
      tens_s     = 2'd3;
      tens_sub_s = 5'd30;
    end else if (mag_s >= 5'd20) begin
      tens_s     = 2'd2;
      tens_sub_s = 5'd20;
    end else if (mag_s >= 5'd10) begin
      tens_s     = 2'd1;
      tens_sub_s = 5'd10;
    end else begin
      tens_s     = 2'd0;
      tens_sub_s = 5'd0;
    end
    ones_s = 4'(mag_s - tens_sub_s);
  end

  // Converted value register.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_r  <= 1'b0;
      tens_r <= 2'd0;
      ones_r <= 4'd0;
    end else begin
      neg_r  <= neg_s;
      tens_r <= tens_s;
      ones_r <= ones_s;
    end
  end

  // Prescaler and digit index advance.
  always_comb begin
    if (presc_r == PRESC_MAX) begin
      presc_next_s = {PW{1'b0}};
      idx_next_s   = idx_r + 2'd1;
    end else begin
      presc_next_s = presc_r + PW'(1);
      idx_next_s   = idx_r;
    end
  end

  // Digit selected for the upcoming cycle, so seg and an switch together.
  always_comb begin
    digit_s = CODE_BLANK;
    case (idx_next_s)
      2'd0: digit_s = ones_r;
      2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (tens_r == 2'd0) begin
          digit_s = CODE_BLANK;
        end else begin
          digit_s = {2'b00, tens_r};
        end
`else
        digit_s = {2'b00, tens_r};
`endif
      end
      2'd2: digit_s = CODE_BLANK;
      2'd3: begin
        if (neg_r) begin
          digit_s = CODE_MINUS;
        end else begin
          digit_s = CODE_BLANK;
        end
      end
      default: digit_s = CODE_BLANK;
    endcase
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
      idx_r   <= 2'd0;
      an_r    <= 4'b1110;
      seg_r   <= 7'b1000000;
    end else begin
      presc_r <= presc_next_s;
      idx_r   <= idx_next_s;
      an_r    <= ~(4'b0001 << idx_next_s);
      seg_r   <= seg_encode(digit_s);
    end
  end

  assign seg = seg_r;
  assign an  = an_r;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display with REFRESH_DIV = 4.
// Works with and without LEADING_ZERO_BLANK_EN.
module tb_result_display;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S6    = 7'b0000010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TZ = 7'b1111111;
`else
  localparam logic [6:0] TZ = 7'b1000000;
`endif

  logic       clk;
  logic       reset;
  logic       load;
  logic [4:0] result;
  logic       mode;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  result_display #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .result (result),
    .mode   (mode),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance until an newly becomes target (first cycle of that digit).
  task automatic wait_an(input logic [3:0] target, input string tag);
    logic [3:0] prev;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      prev = an;
      tick();
      if (an === target && prev !== target) hit = 1'b1;
    end
    n_checks++;
    assert (hit) else begin
      n_fail++;
      $error("FAIL %s: an never became %b, last %b", tag, target, an);
    end
  endtask

  task automatic do_load(input logic [4:0] r, input logic m);
    load = 1'b1; result = r; mode = m;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an;
    reset = 1'b1; load = 1'b0; result = 5'd0; mode = 1'b0;

    // Reset held for three edges, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_an", {3'b000, an}, 7'b0001110);
      check("rst_seg", seg, S0);
      check("rst_dp", {6'd0, dp}, 7'd1);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_an", {3'b000, an}, 7'b0001110);
    end
    tick();
    check("first_advance", {3'b000, an}, 7'b0001101);

    // Add mode 30.
    do_load(5'b11110, 1'b0);
    wait_an(4'b1110, "add_w0");
    check("add_d0", seg, S0);
    wait_an(4'b1101, "add_w1");
    check("add_d1", seg, S3);
    wait_an(4'b1011, "add_w2");
    check("add_d2", seg, BLANK);
    wait_an(4'b0111, "add_w3");
    check("add_d3", seg, BLANK);

    // Subtract -15 with exact two-cycle latency on digit0.
    wait_an(4'b1110, "sub_sync");
    do_load(5'b10001, 1'b1);
    check("lat_n", seg, S0);
    tick();
    check("lat_n1", seg, S0);
    tick();
    check("lat_n2", seg, S5);
    check("lat_n2_an", {3'b000, an}, 7'b0001110);
    wait_an(4'b0111, "sub_w3");
    check("sub_d3", seg, MINUS);
    wait_an(4'b1101, "sub_w1");
    check("sub_d1", seg, S1);
    wait_an(4'b1110, "sub_w0");
    check("sub_d0", seg, S5);

    // Leading zero, 7.
    do_load(5'b00111, 1'b0);
    wait_an(4'b1101, "lz_w1");
    check("lz_d1", seg, TZ);
    wait_an(4'b0111, "lz_w3");
    check("lz_d3", seg, BLANK);
    wait_an(4'b1110, "lz_w0");
    check("lz_d0", seg, S7);

    // -5.
    do_load(5'b11011, 1'b1);
    wait_an(4'b1101, "m5_w1");
    check("m5_d1", seg, TZ);
    wait_an(4'b0111, "m5_w3");
    check("m5_d3", seg, MINUS);
    wait_an(4'b1110, "m5_w0");
    check("m5_d0", seg, S5);

    // -16.
    do_load(5'b10000, 1'b1);
    wait_an(4'b0111, "m16_w3");
    check("m16_d3", seg, MINUS);
    wait_an(4'b1101, "m16_w1");
    check("m16_d1", seg, S1);
    wait_an(4'b1110, "m16_w0");
    check("m16_d0", seg, S6);

    // 31 unsigned.
    do_load(5'b11111, 1'b0);
    wait_an(4'b0111, "p31_w3");
    check("p31_d3", seg, BLANK);
    wait_an(4'b1101, "p31_w1");
    check("p31_d1", seg, S3);
    wait_an(4'b1110, "p31_w0");
    check("p31_d0", seg, S1);

    // Zero in subtract mode: no minus.
    do_load(5'b00000, 1'b1);
    wait_an(4'b0111, "z_w3");
    check("z_d3", seg, BLANK);
    wait_an(4'b1101, "z_w1");
    check("z_d1", seg, TZ);
    wait_an(4'b1110, "z_w0");
    check("z_d0", seg, S0);

    // Back-to-back loads: last one wins.
    load = 1'b1; result = 5'b00001; mode = 1'b0;
    tick();
    result = 5'b00010;
    tick();
    load = 1'b0;
    wait_an(4'b1110, "b2b_w0");
    check("b2b_d0", seg, S2);

    // Load coincident with reset: reset wins.
    wait_an(4'b1011, "lr_sync");
    reset = 1'b1; load = 1'b1; result = 5'b00101; mode = 1'b0;
    tick();
    reset = 1'b0; load = 1'b0;
    check("lr_an", {3'b000, an}, 7'b0001110);
    check("lr_seg", seg, S0);
    wait_an(4'b1110, "lr_w0");
    check("lr_d0", seg, S0);

    // Reset mid-scan.
    wait_an(4'b1011, "mid_sync");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_an", {3'b000, an}, 7'b0001110);
    check("mid_seg", seg, S0);

    // Anode sequence over 40 cycles with a load in the middle.
    wait_an(4'b1101, "scan_sync");
    for (int k = 0; k < 40; k++) begin
      exp_an = ~(4'b0001 << ((1 + k / 4) % 4));
      check("scan_an", {3'b000, an}, {3'b000, exp_an});
      check("scan_dp", {6'd0, dp}, 7'd1);
      if (k == 10) begin
        load = 1'b1; result = 5'b01001; mode = 1'b0;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    wait_an(4'b1110, "scan_w0");
    check("scan_d0", seg, 7'b0010000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
